// File: rtl/fifo_sync_vr.sv
// Single-clock valid/ready FIFO with occupancy count, programmable almost flags and flush.
// Optional high-water-mark tracking is enabled by defining FIFO_SYNC_VR_PEAK_EN.
module fifo_sync_vr #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [PTR_WIDTH:0]    o_count,
  input  logic [PTR_WIDTH:0]    i_af_thresh,
  input  logic [PTR_WIDTH:0]    i_ae_thresh,
  output logic                  o_almost_full,
`ifdef FIFO_SYNC_VR_PEAK_EN
  input  logic                  i_peak_clr,
  output logic [PTR_WIDTH:0]    o_peak_count,
`endif
  output logic                  o_almost_empty
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]    wr_ptr_next, rd_ptr_next;
  logic                  full, empty;
  logic                  wr_beat, rd_beat;

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                 (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

  assign o_ready = !full;
  assign o_valid = !empty;
  assign wr_beat = i_valid && !full;
  assign rd_beat = i_ready && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_beat) wr_ptr_next = wr_ptr + PTR_ONE;
      if (rd_beat) rd_ptr_next = rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_beat && !i_flush) mem[wr_ptr[PTR_WIDTH-1:0]] <= i_data;
  end

  assign o_data         = mem[rd_ptr[PTR_WIDTH-1:0]];
  assign o_count        = wr_ptr - rd_ptr;
  assign o_almost_full  = (o_count >= i_af_thresh);
  assign o_almost_empty = (o_count <= i_ae_thresh);

`ifdef FIFO_SYNC_VR_PEAK_EN
  logic [PTR_WIDTH:0] count_next;

  // Peak tracks the post-edge occupancy, so compare against next-state pointers.
  assign count_next = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_peak_count <= '0;
    end else if (i_peak_clr || (count_next > o_peak_count)) begin
      o_peak_count <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_vr.sv
// Directed bench for fifo_sync_vr: queue-based model compared every cycle plus literal spot checks.
module tb_fifo_sync_vr;
  localparam int DW = 8;
  localparam int PW = 3;
  localparam int DEPTH = 1 << PW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [PW:0]   o_count;
  logic [PW:0]   i_af_thresh = '0;
  logic [PW:0]   i_ae_thresh = '0;
  logic          o_almost_full;
  logic          o_almost_empty;
`ifdef FIFO_SYNC_VR_PEAK_EN
  logic          i_peak_clr = 1'b0;
  logic [PW:0]   o_peak_count;
`endif

  fifo_sync_vr #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_count(o_count), .i_af_thresh(i_af_thresh), .i_ae_thresh(i_ae_thresh),
    .o_almost_full(o_almost_full),
`ifdef FIFO_SYNC_VR_PEAK_EN
    .i_peak_clr(i_peak_clr), .o_peak_count(o_peak_count),
`endif
    .o_almost_empty(o_almost_empty)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents as a queue, peak as a plain integer.
  logic [DW-1:0] q[$];
  int peak_m = 0;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q.delete();
      peak_m = 0;
    end else begin
      bit do_w, do_r;
      do_w = i_valid && (q.size() < DEPTH);
      do_r = i_ready && (q.size() > 0);
      if (i_flush) q.delete();
      else begin
        if (do_r) void'(q.pop_front());
        if (do_w) q.push_back(i_data);
      end
`ifdef FIFO_SYNC_VR_PEAK_EN
      if (i_peak_clr || q.size() > peak_m) peak_m = q.size();
`endif
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("count", int'(o_count), q.size());
      chk("count_bound", int'(o_count <= DEPTH), 1);
      chk("valid", int'(o_valid), int'(q.size() > 0));
      chk("ready", int'(o_ready), int'(q.size() < DEPTH));
      chk("almost_full", int'(o_almost_full), int'(q.size() >= int'(i_af_thresh)));
      chk("almost_empty", int'(o_almost_empty), int'(q.size() <= int'(i_ae_thresh)));
      if (q.size() > 0) chk("data", int'(o_data), int'(q[0]));
`ifdef FIFO_SYNC_VR_PEAK_EN
      chk("peak", int'(o_peak_count), peak_m);
`endif
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int wr_n, rd_n, cyc;

    // Reset state with af threshold 0: almost_full must read 1.
    #1;
    chk("rst_count", int'(o_count), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_ae", int'(o_almost_empty), 1);
    chk("rst_af_thr0", int'(o_almost_full), 1);
    tick();
    i_rst = 1'b1;
    i_af_thresh = 4'd6;
    i_ae_thresh = 4'd1;
    tick();

    // Fill 0x11..0x18 with the consumer stalled.
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      i_data = 8'(8'h11 + i);
      tick();
      if (i == 0) chk("ae_at1", int'(o_almost_empty), 1);
      if (i == 1) chk("ae_at2", int'(o_almost_empty), 0);
      if (i == 4) chk("af_at5", int'(o_almost_full), 0);
      if (i == 5) chk("af_at6", int'(o_almost_full), 1);
    end
    chk("full_count", int'(o_count), 8);
    chk("full_ready", int'(o_ready), 0);
    i_data = 8'h99;
    tick();
    chk("ninth_rejected", int'(o_count), 8);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", int'(o_data), 8'h11 + i);
      tick();
    end
    chk("drained_valid", int'(o_valid), 0);
    i_ready = 1'b0;

    // Single write into an empty FIFO: visible only after the edge.
    i_valid = 1'b1;
    i_data = 8'hA5;
    chk("pre_edge_valid", int'(o_valid), 0);
    tick();
    i_valid = 1'b0;
    chk("post_edge_valid", int'(o_valid), 1);
    chk("post_edge_data", int'(o_data), 8'hA5);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Full with concurrent write and read: only the read is taken.
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      i_data = 8'(8'h20 + i);
      tick();
    end
    i_data = 8'hEE;
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("full_rw_count", int'(o_count), 7);
    chk("full_rw_ready", int'(o_ready), 1);
    chk("full_rw_head", int'(o_data), 8'h21);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;

    // Streaming with random stalls across several pointer wraps.
    wr_n = 0; rd_n = 0; cyc = 0;
    while ((wr_n < 40 || rd_n < 40) && cyc < 2000) begin
      i_valid = (wr_n < 40) && ($urandom_range(0, 3) != 0);
      i_data = 8'(8'h40 + wr_n);
      i_ready = ($urandom_range(0, 2) != 0);
      if (i_valid && o_ready) wr_n++;
      if (i_ready && o_valid) rd_n++;
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("stream_writes", wr_n, 40);
    chk("stream_reads", rd_n, 40);

`ifdef FIFO_SYNC_VR_PEAK_EN
    i_peak_clr = 1'b1;
    tick();
    i_peak_clr = 1'b0;
    chk("peak_cleared", int'(o_peak_count), 0);
`endif
    // Flush at count 5 with a write in the same cycle.
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data = 8'(8'h60 + i);
      tick();
    end
    chk("pre_flush_count", int'(o_count), 5);
    i_flush = 1'b1;
    i_data = 8'h77;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_count", int'(o_count), 0);
    chk("flush_valid", int'(o_valid), 0);
    chk("flush_ready", int'(o_ready), 1);
`ifdef FIFO_SYNC_VR_PEAK_EN
    chk("flush_peak", int'(o_peak_count), 5);
`endif

    // Asynchronous reset in mid-operation.
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data = 8'(8'h80 + i);
      tick();
    end
    i_valid = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    chk("midrst_count", int'(o_count), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_ready", int'(o_ready), 1);
    tick();
    i_rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
